// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller link: button ordering, frame length
// and the pad-side FSM state encoding.
package nes_pkg;

  localparam int NES_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [3:0] CNT_FULL = 4'(NES_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_e;

endpackage

// File: rtl/nes_pad_responder_if.sv
// Pad-side bundle of the controller link: host strobes and buttons in,
// serial data and frame status out.
interface nes_pad_responder_if;
  import nes_pkg::*;

  logic [NES_BITS-1:0] buttons_in;
  logic                nes_latch;
  logic                nes_pulse;
  logic                nes_data;
  logic                busy;
  logic                frame_done;
  logic [3:0]          shift_count;

  modport master (
    output buttons_in, nes_latch, nes_pulse,
    input  nes_data, busy, frame_done, shift_count
  );

  modport slave (
    input  buttons_in, nes_latch, nes_pulse,
    output nes_data, busy, frame_done, shift_count
  );

endinterface

// File: rtl/nes_edge_sync.sv
// Multi-flop synchronizer for an asynchronous strobe, with rise/fall detection
// taken from the last stage against one extra flop.
module nes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync_q [SYNC_STAGES];
  logic last_q;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= d_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= sync_q[SYNC_STAGES-1];
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES gamepad emulation: answers host latch/pulse strobes and shifts out eight
// active-low button bits the way a 4021-based pad does.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  nes_pad_responder_if.slave pad
);

  logic latch_rise, latch_fall, pulse_rise, pulse_fall;

  nes_state_e          state_q, state_d;
  logic [NES_BITS-1:0] sreg_q, sreg_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pad.nes_latch),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pad.nes_pulse),
    .rise_o (pulse_rise),
    .fall_o (pulse_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // A relatch overrides everything, including a pulse landing in the same cycle.
    if (latch_rise) begin
      state_d = LOAD;
      sreg_d  = ~pad.buttons_in;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          sreg_d = ~pad.buttons_in;
          if (latch_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        SHIFT: begin
          if (pulse_rise) begin
            sreg_d = {FILL_BIT, sreg_q[NES_BITS-1:1]};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == CNT_FULL - 4'd1) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (pulse_rise) sreg_d = {FILL_BIT, sreg_q[NES_BITS-1:1]};
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulse falls carry no meaning for the pad; consumed here to keep the port tidy.
  logic unused_pulse_fall;
  assign unused_pulse_fall = pulse_fall;

  assign pad.nes_data    = sreg_q[0];
  assign pad.busy        = busy_q;
  assign pad.frame_done  = done_q;
  assign pad.shift_count = cnt_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Randomized bench for nes_pad_responder against a frame-level pad model.
module tb_nes_pad_responder;
  import nes_pkg::*;

  localparam int   SYNC   = 2;
  localparam logic FILL   = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   fd_cnt = 0;
  int   fd_misaligned = 0;

  nes_pad_responder_if pad_if ();

  nes_pad_responder #(.SYNC_STAGES(SYNC), .FILL_BIT(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pad_if)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (pad_if.frame_done) fd_cnt <= fd_cnt + 1;
  always @(negedge clk)
    if (pad_if.frame_done && pad_if.shift_count != 4'd8) fd_misaligned <= fd_misaligned + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_strobe(input int hi, input int lo);
    pad_if.nes_latch = 1'b1;
    wait_cyc(hi);
    pad_if.nes_latch = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic pulse_strobe(input int hi, input int lo);
    pad_if.nes_pulse = 1'b1;
    wait_cyc(hi);
    pad_if.nes_pulse = 1'b0;
    wait_cyc(lo);
  endtask

  // Frame model: after k shifts the pad shows bit k of the latched (inverted)
  // buttons, or the fill level once all eight have gone.
  task automatic check_step(input string tag, input int k, input logic [7:0] exp_bits);
    logic exp_d;
    int   exp_c;
    exp_d = (k < NES_BITS) ? exp_bits[k] : FILL;
    exp_c = (k < NES_BITS) ? k : NES_BITS;
    check_val($sformatf("%s k=%0d data", tag, k), 32'(pad_if.nes_data), 32'(exp_d));
    check_val($sformatf("%s k=%0d count", tag, k), 32'(pad_if.shift_count), 32'(exp_c));
    check_val($sformatf("%s k=%0d busy", tag, k), 32'(pad_if.busy), 32'(k < NES_BITS));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] btn, input int npulses, input bit wiggle);
    logic [7:0] exp_bits;
    int         fd0;
    pad_if.buttons_in = btn;
    latch_strobe($urandom_range(6, 30), $urandom_range(6, 20));
    exp_bits = ~btn;
    fd0 = fd_cnt;
    check_step(tag, 0, exp_bits);
    if (wiggle) pad_if.buttons_in = 8'($urandom);
    for (int k = 1; k <= npulses; k++) begin
      pulse_strobe($urandom_range(5, 20), $urandom_range(5, 20));
      check_step(tag, k, exp_bits);
    end
    check_val({tag, " frame_done count"}, 32'(fd_cnt - fd0), 32'(npulses >= NES_BITS));
  endtask

  initial begin
    logic [7:0] exp_bits;
    pad_if.buttons_in = 8'h00;
    pad_if.nes_latch  = 1'b0;
    pad_if.nes_pulse  = 1'b0;

    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(5);
    check_val("reset data", 32'(pad_if.nes_data), 32'd1);
    check_val("reset busy", 32'(pad_if.busy), 32'd0);
    check_val("reset count", 32'(pad_if.shift_count), 32'd0);
    check_val("reset frame_done", 32'(pad_if.frame_done), 32'd0);
    for (int i = 0; i < 3; i++) pulse_strobe(8, 8);
    check_val("idle pulses data", 32'(pad_if.nes_data), 32'd1);
    check_val("idle pulses count", 32'(pad_if.shift_count), 32'd0);

    run_frame("full", 8'b1000_0101, 8, 1'b0);
    run_frame("overshift", 8'b1000_0101, 12, 1'b0);

    pad_if.buttons_in = 8'h01;
    latch_strobe(10, 10);
    exp_bits = ~8'h01;
    for (int k = 1; k <= 3; k++) begin
      pulse_strobe(8, 8);
      check_step("relatch pre", k, exp_bits);
    end
    pad_if.buttons_in = 8'h02;
    pad_if.nes_latch  = 1'b1;
    wait_cyc(8);
    check_val("relatch count", 32'(pad_if.shift_count), 32'd0);
    check_val("relatch busy", 32'(pad_if.busy), 32'd0);
    pad_if.nes_latch = 1'b0;
    wait_cyc(8);
    exp_bits = ~8'h02;
    check_step("relatch", 0, exp_bits);
    for (int k = 1; k <= 8; k++) begin
      pulse_strobe(8, 8);
      check_step("relatch", k, exp_bits);
    end

    pad_if.buttons_in = 8'h01;
    pad_if.nes_latch  = 1'b1;
    wait_cyc(8);
    for (int i = 0; i < 5; i++) pulse_strobe(6, 6);
    pad_if.nes_latch = 1'b0;
    wait_cyc(8);
    exp_bits = ~8'h01;
    check_step("pulse-in-latch", 0, exp_bits);
    pulse_strobe(8, 8);
    check_step("pulse-in-latch", 1, exp_bits);

    pad_if.buttons_in = 8'hA6;
    latch_strobe(10, 10);
    pulse_strobe(8, 8);
    pulse_strobe(8, 8);
    pad_if.buttons_in = 8'h5C;
    pad_if.nes_latch  = 1'b1;
    pad_if.nes_pulse  = 1'b1;
    wait_cyc(8);
    exp_bits = ~8'h5C;
    check_val("collision count", 32'(pad_if.shift_count), 32'd0);
    check_val("collision busy", 32'(pad_if.busy), 32'd0);
    check_val("collision data", 32'(pad_if.nes_data), 32'(exp_bits[0]));
    pad_if.nes_pulse = 1'b0;
    wait_cyc(8);
    pad_if.nes_latch = 1'b0;
    wait_cyc(8);
    check_step("collision", 0, exp_bits);
    for (int k = 1; k <= 8; k++) begin
      pulse_strobe(8, 8);
      check_step("collision", k, exp_bits);
    end

    for (int f = 0; f < 20; f++)
      run_frame($sformatf("rand%0d", f), 8'($urandom), $urandom_range(0, 11), 1'($urandom_range(0, 1)));

    pad_if.buttons_in = 8'h0F;
    latch_strobe(10, 10);
    for (int i = 0; i < 3; i++) pulse_strobe(8, 8);
    reset = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(4);
    check_val("midreset data", 32'(pad_if.nes_data), 32'd1);
    check_val("midreset count", 32'(pad_if.shift_count), 32'd0);
    check_val("midreset busy", 32'(pad_if.busy), 32'd0);
    pulse_strobe(8, 8);
    pulse_strobe(8, 8);
    check_val("midreset idle data", 32'(pad_if.nes_data), 32'd1);
    check_val("midreset idle count", 32'(pad_if.shift_count), 32'd0);

    check_val("frame_done alignment", 32'(fd_misaligned), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
